// File: rtl/reg_file_wb_arbiter.sv
// reg_file_wb_arbiter: write-back arbiter and RAW hazard scoreboard for the
// 32-entry register file.
//   Two write-back requesters (req0 = ALU, req1 = load/multi-cycle unit) share
//   the single reg_file write port through a round-robin arbiter. Issue claims
//   destination registers into a pending scoreboard; decode stalls on them.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/addr/data/ready    write-back request handshake (N = 0, 1)
//   claim_valid/claim_addr        issue-stage destination reservation
//   rs_addr, rt_addr, stall       decode source operands and hazard stall
//   rdwr, addr3, data3            registered reg_file write port
//   fwd_rs_en, fwd_rt_en, fwd_data  commit-stage bypass
// Optional feature: define WB_BYPASS_EN to forward the committing write to
// decode instead of stalling on it.
module reg_file_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              stall,
  output logic              rdwr,
  output logic [ADDR_W-1:0] addr3,
  output logic [DATA_W-1:0] data3,
  output logic              fwd_rs_en,
  output logic              fwd_rt_en,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  logic              prio;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic              gnt0;
  logic              gnt1;
  logic              gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              pend_hit;
  logic              commit_rs;
  logic              commit_rt;

  // Round-robin grant; prio only matters when both requesters are valid.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    gnt_addr = req0_addr;
    gnt_data = req0_data;
    if (!rst) begin
      gnt0 = req0_valid && (!req1_valid || !prio);
      gnt1 = req1_valid && (!req0_valid ||  prio);
    end
    if (gnt1) begin
      gnt_addr = req1_addr;
      gnt_data = req1_data;
    end
  end

  assign gnt_any    = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Scoreboard update: clear on grant, then set on claim so a new producer wins.
  always_comb begin
    pending_nxt = pending;
    if (gnt_any) begin
      pending_nxt[gnt_addr] = 1'b0;
    end
    if (claim_valid && (claim_addr != ZERO_REG)) begin
      pending_nxt[claim_addr] = 1'b1;
    end
  end

  // Arbiter priority, scoreboard and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio    <= 1'b0;
      pending <= '0;
      rdwr    <= 1'b0;
      addr3   <= '0;
      data3   <= '0;
    end else begin
      pending <= pending_nxt;
      if (gnt_any) begin
        prio  <= gnt0;
        addr3 <= gnt_addr;
        data3 <= gnt_data;
        rdwr  <= (gnt_addr != ZERO_REG);
      end else begin
        rdwr  <= 1'b0;
      end
    end
  end

  assign pend_hit = ((rs_addr != ZERO_REG) && pending[rs_addr]) ||
                    ((rt_addr != ZERO_REG) && pending[rt_addr]);

  // The write registered in addr3/data3 lands in reg_file at the coming edge,
  // so a same-cycle read of that register still returns the old value.
  assign commit_rs = rdwr && (rs_addr != ZERO_REG) && (addr3 == rs_addr);
  assign commit_rt = rdwr && (rt_addr != ZERO_REG) && (addr3 == rt_addr);

`ifdef WB_BYPASS_EN
  assign fwd_rs_en = commit_rs;
  assign fwd_rt_en = commit_rt;
  assign fwd_data  = data3;
  assign stall     = pend_hit;
`else
  assign fwd_rs_en = 1'b0;
  assign fwd_rt_en = 1'b0;
  assign fwd_data  = '0;
  assign stall     = pend_hit || commit_rs || commit_rt;
`endif

endmodule
